// File: rtl/prog_truthtable.sv
// prog_truthtable: run-time loadable truth table with registered lookup.
// Rows are written in order after a load_start; once the last row is written
// the table arms and each in_valid returns its row one cycle later.
// Optional feature macro: PROG_TRUTHTABLE_HITCNT_EN adds a saturating 16-bit
// hit_count of results whose f[0] is 1.
module prog_truthtable #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [N_OUT-1:0] load_data,
  output logic             load_done,
  output logic             table_ready,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  output logic [N_OUT-1:0] f,
  output logic             eval_err
`ifdef PROG_TRUTHTABLE_HITCNT_EN
  ,
  output logic [15:0]      hit_count
`endif
);

  localparam int unsigned    ROWS     = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   ptr_q, ptr_d;
  logic [N_OUT-1:0]  tbl_q [ROWS];
  logic              wr_en;
  logic [N_IN-1:0]   wr_row;
  logic              load_done_d;
  logic              out_valid_d;
  logic              eval_err_d;
  logic [N_OUT-1:0]  f_d;

  // Next-state, row write control and evaluation result selection.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_en       = 1'b0;
    wr_row      = ptr_q;
    load_done_d = 1'b0;
    out_valid_d = 1'b0;
    eval_err_d  = 1'b0;
    f_d         = f;
    if (load_start) begin
      // load_start wins over any evaluation, so a concurrent in_valid is rejected
      state_d    = LOADING;
      ptr_d      = '0;
      eval_err_d = in_valid;
      if (load_valid) begin
        wr_en  = 1'b1;
        wr_row = '0;
        ptr_d  = N_IN'(1);
      end
    end else begin
      case (state_q)
        EMPTY: begin
          eval_err_d = in_valid;
        end
        LOADING: begin
          eval_err_d = in_valid;
          if (load_valid) begin
            wr_en = 1'b1;
            if (ptr_q == LAST_ROW) begin
              // pointer parks on the last row; arming happens on this edge
              load_done_d = 1'b1;
              state_d     = ARMED;
            end else begin
              ptr_d = ptr_q + N_IN'(1);
            end
          end
        end
        ARMED: begin
          if (in_valid) begin
            out_valid_d = 1'b1;
            f_d         = tbl_q[in_x];
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and row pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Table storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_q[wr_row] <= load_data;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_done   <= 1'b0;
      table_ready <= 1'b0;
      out_valid   <= 1'b0;
      eval_err    <= 1'b0;
      f           <= '0;
    end else begin
      load_done   <= load_done_d;
      table_ready <= (state_d == ARMED);
      out_valid   <= out_valid_d;
      eval_err    <= eval_err_d;
      f           <= f_d;
    end
  end

`ifdef PROG_TRUTHTABLE_HITCNT_EN
  // Saturating count of results with f[0]=1, updated with the result itself.
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      hit_count <= 16'd0;
    end else if (out_valid_d && f_d[0] && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_truthtable.sv
// tb_prog_truthtable: directed scenarios plus random traffic for prog_truthtable
// (N_IN=3, N_OUT=1), checked each cycle against a behavioural table model.
module tb_prog_truthtable;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [0:0] load_data = 1'b0;
  logic       load_done;
  logic       table_ready;
  logic       in_valid = 1'b0;
  logic [2:0] in_x = 3'd0;
  logic       out_valid;
  logic [0:0] f;
  logic       eval_err;
`ifdef PROG_TRUTHTABLE_HITCNT_EN
  logic [15:0] hit_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: table contents, mode (0 empty, 1 loading, 2 armed),
  // next row to write, last result and hit count.
  bit [0:0] m_tbl [8];
  int       m_mode = 0;
  int       m_ptr  = 0;
  bit [0:0] m_f    = 1'b0;
  int       m_hits = 0;

  prog_truthtable #(.N_IN(3), .N_OUT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .table_ready (table_ready),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .f           (f),
    .eval_err    (eval_err)
`ifdef PROG_TRUTHTABLE_HITCNT_EN
    ,
    .hit_count   (hit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input bit r, input bit ls, input bit lv, input bit ld,
                      input bit iv, input bit [2:0] ix);
    bit e_ov, e_err, e_done;
    reset      = r;
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    in_valid   = iv;
    in_x       = ix;
    e_ov = 1'b0; e_err = 1'b0; e_done = 1'b0;
    if (r) begin
      foreach (m_tbl[i]) m_tbl[i] = 1'b0;
      m_mode = 0; m_ptr = 0; m_f = 1'b0; m_hits = 0;
    end else if (ls) begin
      e_err  = iv;
      m_mode = 1;
      m_ptr  = 0;
      m_hits = 0;
      if (lv) begin
        m_tbl[0] = ld;
        m_ptr    = 1;
      end
    end else if (m_mode == 0) begin
      e_err = iv;
    end else if (m_mode == 1) begin
      e_err = iv;
      if (lv) begin
        m_tbl[m_ptr] = ld;
        if (m_ptr == 7) begin
          e_done = 1'b1;
          m_mode = 2;
        end else begin
          m_ptr++;
        end
      end
    end else if (iv) begin
      e_ov = 1'b1;
      m_f  = m_tbl[ix];
      if (m_f == 1'b1 && m_hits < 65535) m_hits++;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("eval_err", 32'(eval_err), 32'(e_err));
    chk("load_done", 32'(load_done), 32'(e_done));
    chk("table_ready", 32'(table_ready), 32'(m_mode == 2));
    chk("f", 32'(f), 32'(m_f));
`ifdef PROG_TRUTHTABLE_HITCNT_EN
    chk("hit_count", 32'(hit_count), 32'(m_hits));
`endif
  endtask

  initial begin
    bit [0:0] pat [8];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 5);

    // evaluation while empty is rejected; stray load_valid is ignored
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 1, 1, 0, 0);

    // load the reference table with a hold cycle and an eval on the final write
    step(0, 1, 1, pat[0], 0, 0);
    for (int i = 1; i < 8; i++) begin
      if (i == 4) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 1, pat[i], (i == 7), 3'(i));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 3'(i));
    step(0, 0, 0, 0, 0, 0);

    // load_valid while armed leaves the table intact
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3);

    // load_start beats a concurrent evaluation; reload all ones
    step(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 5);

    // reset mid-load, reject eval, then reload and evaluate everything
    step(0, 1, 1, pat[0], 0, 0);
    for (int i = 1; i < 4; i++) step(0, 0, 1, pat[i], 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, pat[0], 0, 0);
    for (int i = 1; i < 8; i++) step(0, 0, 1, pat[i], 0, 0);
    for (int i = 7; i >= 0; i--) step(0, 0, 0, 0, 1, 3'(i));

    // restart mid-load keeps older rows until rewritten
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    for (int i = 1; i < 8; i++) step(0, 0, 1, pat[i], 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 3'(i));

    // hit count over two passes, then cleared by load_start
    step(0, 1, 1, pat[0], 0, 0);
    for (int i = 1; i < 8; i++) step(0, 0, 1, pat[i], 0, 0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 3'(i));
`ifdef PROG_TRUTHTABLE_HITCNT_EN
    chk("hit_count_two_passes", 32'(hit_count), 32'd8);
`endif
    step(0, 1, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(199) == 0), ($urandom_range(29) == 0),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 3'($urandom_range(7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
